sgd_dispatch_b: RTL and testbench
=================================

Name: sgd_dispatch_b

Overview:
Producer side of the label stream feeding the serial loss stage. It takes 512-bit HBM read beats carrying sixteen 32-bit fixed-point labels b, splits each into two 256-bit words (one 32-bit lane per bank), and writes them as dispatch_axb_b_data / dispatch_axb_b_wr_en. It obeys dispatch_axb_b_almost_full and zero-pads the tail of each epoch. It runs in the HBM clock domain on the write side of the clock-crossing b FIFO.

Parameters:
NUM_OF_BANKS, 8, lanes per output word (32 bits each).
IN_WIDTH, 512, HBM beat width; carries IN_WIDTH/32 = 16 labels, i.e. 2 output words.

Ports:
hbm_clk  input  1  clock.
rst  input  1  reset; asynchronous, active-high.
start  input  1  one-cycle pulse; begins a job; sampled only in IDLE.
number_of_samples  input  32  N, labels per epoch; sampled on accepted start.
number_of_epochs  input  32  E; sampled on accepted start.
hbm_b_data  input  IN_WIDTH  label beat; lane i = bits [32i+31:32i]; lane 0 is the earliest sample.
hbm_b_valid  input  1  beat valid.
hbm_b_ready  output  1  beat accepted when valid & ready.
dispatch_axb_b_data  output  32*NUM_OF_BANKS  output word; lane j = bank j.
dispatch_axb_b_wr_en  output  1  write strobe, one word per cycle.
dispatch_axb_b_almost_full  input  1  downstream FIFO prog_full.
busy  output  1  high outside IDLE.
done  output  1  one-cycle pulse at job end.
b_out_cnt  output  32  words written since last accepted start.

Behaviour:
- Reset (async, rst=1): state IDLE; hold register empty; all counters 0. Outputs hbm_b_ready, dispatch_axb_b_data, dispatch_axb_b_wr_en, busy, done and b_out_cnt are all 0. Asserting reset mid-job aborts the job; no further writes occur until a new start.
- States: IDLE -> RUN on start. RUN -> DONE after the last output word of epoch E. DONE -> IDLE after 1 cycle, with done=1 during DONE. If N==0 or E==0: IDLE -> DONE directly, with no writes.
- Per epoch: out_words = ceil(N/8); in_beats = ceil(N/16). If out_words is odd, the upper half of the final beat is discarded.
- Hold register: one IN_WIDTH beat plus a half-select bit.
  - Emit condition: RUN & hold valid & !almost_full. Each emit sends the selected half (low half first).
  - The hold register frees after its last half is emitted.
- hbm_b_ready = RUN & beats remaining in this epoch > 0 & (hold empty | last half of hold emitting this cycle). This is combinational on almost_full, so steady-state throughput is one word per cycle.
- Output is registered: a handshake in cycle c produces the low-half wr_en in cycle c+2 and the high half in c+3, assuming almost_full=0.
- While almost_full=1: wr_en=0 and the hold state is frozen; no word is lost or duplicated. Deassertion resumes from the exact pending half. almost_full can stall between the two halves of a beat.
- Tail padding: in the final word of an epoch, lanes with sample index >= N are driven 0.
- Epoch wrap: after word out_words-1 the word/beat counters clear and the epoch counter increments. The next epoch begins with no idle cycle. Extra valid beats beyond in_beats of an epoch belong to the next epoch, and are never accepted after the final epoch.
- dispatch_axb_b_data holds its last value when wr_en=0.
- b_out_cnt increments on every wr_en; it clears on an accepted start, not on done.
- start while busy is ignored. Counter widths are 32 bits; N up to 2^32-1 is supported without overflow of the ceil computation (33-bit intermediate).

Test Plan:
1. N=16, E=1, one beat of lanes 1..16 -> words {1..8} then {9..16} in consecutive cycles; done pulses once; b_out_cnt=2.
2. N=20, E=1, beats of lanes 1..16 and 17..32 -> 3 words; third word = {17,18,19,20,0,0,0,0}; lanes 21..32 dropped; ready low afterwards.
3. N=32, E=3, valid held high -> 12 words, back-to-back wr_en after the first; single done; b_out_cnt=12.
4. N=32, E=1, almost_full high for 10 cycles right after the first word -> no wr_en during the stall; words 2..4 intact and in order after release.
5. start with N=0 (E=5) -> done within 2 cycles; zero wr_en; ready never high; start pulsed during a busy job is ignored.
6. rst pulsed mid-epoch 2 of a N=64, E=3 job -> outputs 0 immediately; a fresh N=16, E=1 job then completes exactly as in scenario 1.

Source files
------------

// File: rtl/sgd_dispatch_b_if.sv
// sgd_dispatch_b_if: HBM label-beat stream in, bank-word write stream out.
interface sgd_dispatch_b_if #(
   parameter int NUM_OF_BANKS = 8,
   parameter int IN_WIDTH     = 512
);
   logic [IN_WIDTH-1:0]         hbm_b_data;
   logic                        hbm_b_valid;
   logic                        hbm_b_ready;
   logic [32*NUM_OF_BANKS-1:0]  dispatch_axb_b_data;
   logic                        dispatch_axb_b_wr_en;
   logic                        dispatch_axb_b_almost_full;
   modport master (
      output hbm_b_data, hbm_b_valid, dispatch_axb_b_almost_full,
      input  hbm_b_ready, dispatch_axb_b_data, dispatch_axb_b_wr_en
   );
   modport slave (
      input  hbm_b_data, hbm_b_valid, dispatch_axb_b_almost_full,
      output hbm_b_ready, dispatch_axb_b_data, dispatch_axb_b_wr_en
   );
endinterface

// File: rtl/sgd_dispatch_b.sv
// sgd_dispatch_b: splits 512-bit label beats into two bank words per beat, zero-pads each epoch tail.
module sgd_dispatch_b #(
   parameter int NUM_OF_BANKS = 8,
   parameter int IN_WIDTH     = 512
) (
   input  logic                 hbm_clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [31:0]          number_of_samples,
   input  logic [31:0]          number_of_epochs,
   sgd_dispatch_b_if.slave      bif,
   output logic                 busy,
   output logic                 done,
   output logic [31:0]          b_out_cnt
);
   localparam int W  = 32*NUM_OF_BANKS;
   localparam int LB = $clog2(NUM_OF_BANKS);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_nx;
   logic [31:0] n_r, e_r, ow_r, ib_r, word_cnt, beat_cnt, epoch_cnt;
   logic [IN_WIDTH-1:0] hold_d;
   logic hold_v, sel, wr_en_r;
   logic [W-1:0] half, word, out_d;
   logic [63:0] base;
   logic run, emit, hold_last, ep_end, last_ep, frees, ready, acc;
   assign run       = state == RUN;
   assign emit      = run & hold_v & !bif.dispatch_axb_b_almost_full;
   assign hold_last = sel | (word_cnt == ow_r - 32'd1);
   assign ep_end    = emit & (word_cnt == ow_r - 32'd1);
   assign last_ep   = epoch_cnt == e_r - 32'd1;
   assign frees     = emit & hold_last;
   // The final word of an epoch may free the hold for the next epoch's first beat in the same cycle.
   assign ready     = run & (!hold_v | frees) & ((beat_cnt < ib_r) | (ep_end & !last_ep));
   assign acc       = ready & bif.hbm_b_valid;
   assign half      = sel ? hold_d[IN_WIDTH-1:W] : hold_d[W-1:0];
   assign base      = 64'(word_cnt) * 64'(NUM_OF_BANKS);
   always_comb begin
      word = '0;
      for (int j = 0; j < NUM_OF_BANKS; j++)
         word[32*j +: 32] = (base + 64'(j)) < {32'd0, n_r} ? half[32*j +: 32] : 32'd0;
   end
   always_comb begin
      state_nx = state;
      state_nx = state == IDLE ? (start ? ((number_of_samples == 32'd0 || number_of_epochs == 32'd0) ? DONE : RUN) : IDLE)
               : state == RUN  ? ((ep_end & last_ep) ? DONE : RUN)
               : IDLE;
   end
   always_ff @(posedge hbm_clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         n_r       <= '0;
         e_r       <= '0;
         ow_r      <= '0;
         ib_r      <= '0;
         word_cnt  <= '0;
         beat_cnt  <= '0;
         epoch_cnt <= '0;
         hold_d    <= '0;
         hold_v    <= 1'b0;
         sel       <= 1'b0;
         wr_en_r   <= 1'b0;
         out_d     <= '0;
         b_out_cnt <= '0;
      end else begin
         state   <= state_nx;
         wr_en_r <= emit;
         if (emit) out_d <= word;
         if (acc) hold_d <= bif.hbm_b_data;
         if (state == IDLE && start) begin
            n_r       <= number_of_samples;
            e_r       <= number_of_epochs;
            ow_r      <= 32'(({1'b0, number_of_samples} + 33'(NUM_OF_BANKS - 1)) >> LB);
            ib_r      <= 32'(({1'b0, number_of_samples} + 33'(2*NUM_OF_BANKS - 1)) >> (LB + 1));
            word_cnt  <= '0;
            beat_cnt  <= '0;
            epoch_cnt <= '0;
            hold_v    <= 1'b0;
            sel       <= 1'b0;
            b_out_cnt <= '0;
         end else begin
            hold_v    <= acc | (hold_v & !frees);
            sel       <= !(acc | frees) & (sel | emit);
            word_cnt  <= ep_end ? 32'd0 : word_cnt + 32'(emit);
            beat_cnt  <= ep_end ? 32'(acc) : beat_cnt + 32'(acc);
            epoch_cnt <= epoch_cnt + 32'(ep_end);
            b_out_cnt <= b_out_cnt + 32'(emit);
         end
      end
   end
   assign bif.hbm_b_ready          = ready;
   assign bif.dispatch_axb_b_data  = out_d;
   assign bif.dispatch_axb_b_wr_en = wr_en_r;
   assign busy = state != IDLE;
   assign done = state == DONE;
endmodule

// File: tb/tb_sgd_dispatch_b.sv
// tb_sgd_dispatch_b: directed scenarios for the label dispatcher with hand-derived expected words.
module tb_sgd_dispatch_b;
   logic hbm_clk = 1'b0;
   logic rst, start, busy, done, abort;
   logic [31:0] n_s, e_s, b_out_cnt;
   int checks = 0, errors = 0, cyc = 0, acc_cnt = 0, done_cnt = 0, rdy_cnt = 0;
   logic [255:0] wq[$];
   int wt[$];
   sgd_dispatch_b_if #(.NUM_OF_BANKS(8), .IN_WIDTH(512)) bif();
   sgd_dispatch_b #(.NUM_OF_BANKS(8), .IN_WIDTH(512)) dut (
      .hbm_clk(hbm_clk), .rst(rst), .start(start), .number_of_samples(n_s),
      .number_of_epochs(e_s), .bif(bif.slave), .busy(busy), .done(done), .b_out_cnt(b_out_cnt)
   );
   always #5 hbm_clk = ~hbm_clk;
   always @(negedge hbm_clk) begin
      cyc++;
      if (bif.dispatch_axb_b_wr_en) begin
         wq.push_back(bif.dispatch_axb_b_data);
         wt.push_back(cyc);
      end
      if (done) done_cnt++;
      if (bif.hbm_b_ready) rdy_cnt++;
   end
   always @(posedge hbm_clk) if (bif.hbm_b_valid && bif.hbm_b_ready) acc_cnt <= acc_cnt + 1;
   function automatic logic [511:0] bt(input int first);
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[32*i +: 32] = 32'(first + i);
      return r;
   endfunction
   function automatic logic [255:0] ew(input int first, input int n);
      logic [255:0] r;
      for (int j = 0; j < 8; j++) r[32*j +: 32] = (first + j <= n) ? 32'(first + j) : 32'd0;
      return r;
   endfunction
   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic go(input int n, input int e);
      @(negedge hbm_clk);
      start = 1'b1; n_s = 32'(n); e_s = 32'(e);
      @(negedge hbm_clk);
      start = 1'b0;
   endtask
   task automatic send(input int nb, input int per);
      int base_acc = acc_cnt;
      for (int k = 0; k < nb && !abort; k++) begin
         int t = 0;
         bif.hbm_b_valid = 1'b1;
         bif.hbm_b_data  = bt(1 + 16*(k % per));
         while (acc_cnt <= base_acc + k && !abort && t < 400) begin
            @(negedge hbm_clk);
            t++;
         end
         if (!abort) chk("beat_accept_timeout", t < 400, 1);
      end
      bif.hbm_b_valid = 1'b0;
   endtask
   task automatic wait_done(input int budget);
      int t = 0;
      while (!done && t < budget) begin
         @(negedge hbm_clk);
         t++;
      end
      chk("done_timeout", t < budget, 1);
   endtask
   task automatic chk_words(input string tag, input int w0, input int cnt, input int per, input int n);
      chk({tag, "_count"}, wq.size() - w0, cnt);
      for (int k = 0; k < cnt; k++)
         chk({tag, "_word"}, (w0 + k < wq.size()) ? wq[w0 + k] : 'x, ew(1 + 8*(k % per), n));
   endtask
   task automatic job16(input string tag);
      int w0 = wq.size(), d0 = done_cnt;
      go(16, 1);
      fork
         send(1, 1);
         wait_done(100);
      join
      repeat (2) @(negedge hbm_clk);
      chk_words(tag, w0, 2, 2, 16);
      chk({tag, "_b2b"}, (w0 + 1 < wt.size()) ? wt[w0 + 1] - wt[w0] : -1, 1);
      chk({tag, "_done"}, done_cnt - d0, 1);
      chk({tag, "_cnt"}, b_out_cnt, 2);
      chk({tag, "_busy"}, busy, 0);
   endtask
   initial begin
      int w0, d0, r0, a0, t, stall_wr;
      rst = 1'b1; start = 1'b0; n_s = '0; e_s = '0; abort = 1'b0;
      bif.hbm_b_valid = 1'b0; bif.hbm_b_data = '0; bif.dispatch_axb_b_almost_full = 1'b0;
      repeat (2) @(negedge hbm_clk);
      chk("rst_ready", bif.hbm_b_ready, 0);
      chk("rst_wr_en", bif.dispatch_axb_b_wr_en, 0);
      chk("rst_data", bif.dispatch_axb_b_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_cnt", b_out_cnt, 0);
      rst = 1'b0;
      job16("s1");
      // N=20: three words, last one padded, upper half of the second beat dropped
      w0 = wq.size(); d0 = done_cnt;
      go(20, 1);
      fork
         send(2, 2);
         wait_done(100);
      join
      repeat (2) @(negedge hbm_clk);
      chk_words("s2", w0, 3, 3, 20);
      chk("s2_done", done_cnt - d0, 1);
      chk("s2_cnt", b_out_cnt, 3);
      a0 = acc_cnt;
      bif.hbm_b_valid = 1'b1; bif.hbm_b_data = bt(33);
      repeat (3) @(negedge hbm_clk);
      chk("s2_idle_ready", bif.hbm_b_ready, 0);
      chk("s2_no_extra_accept", acc_cnt - a0, 0);
      bif.hbm_b_valid = 1'b0;
      // three epochs streamed back to back
      w0 = wq.size(); d0 = done_cnt;
      go(32, 3);
      fork
         send(6, 2);
         wait_done(200);
      join
      repeat (2) @(negedge hbm_clk);
      chk_words("s3", w0, 12, 4, 32);
      chk("s3_b2b", (w0 + 11 < wt.size()) ? wt[w0 + 11] - wt[w0] : -1, 11);
      chk("s3_done", done_cnt - d0, 1);
      chk("s3_cnt", b_out_cnt, 12);
      // almost_full stall between the two halves of the first beat
      w0 = wq.size(); d0 = done_cnt; stall_wr = 0;
      go(32, 1);
      fork
         send(2, 2);
         begin
            t = 0;
            while (!bif.dispatch_axb_b_wr_en && t < 50) begin
               @(negedge hbm_clk);
               t++;
            end
            chk("s4_first_word_timeout", t < 50, 1);
            bif.dispatch_axb_b_almost_full = 1'b1;
            repeat (10) begin
               @(negedge hbm_clk);
               if (bif.dispatch_axb_b_wr_en) stall_wr++;
            end
            chk("s4_words_at_release", wq.size() - w0, 1);
            bif.dispatch_axb_b_almost_full = 1'b0;
         end
         wait_done(300);
      join
      repeat (2) @(negedge hbm_clk);
      chk("s4_stall_wr", stall_wr, 0);
      chk_words("s4", w0, 4, 4, 32);
      chk("s4_done", done_cnt - d0, 1);
      chk("s4_cnt", b_out_cnt, 4);
      // empty job, then a start pulse during a running job
      w0 = wq.size(); d0 = done_cnt; r0 = rdy_cnt;
      go(0, 5);
      wait_done(2);
      repeat (2) @(negedge hbm_clk);
      chk("s5_zero_words", wq.size() - w0, 0);
      chk("s5_no_ready", rdy_cnt - r0, 0);
      chk("s5_done", done_cnt - d0, 1);
      chk("s5_cnt", b_out_cnt, 0);
      w0 = wq.size(); d0 = done_cnt;
      go(16, 1);
      go(0, 1);
      chk("s5_busy_kept", busy, 1);
      chk("s5_no_early_done", done_cnt - d0, 0);
      fork
         send(1, 1);
         wait_done(100);
      join
      repeat (2) @(negedge hbm_clk);
      chk_words("s5b", w0, 2, 2, 16);
      chk("s5b_done", done_cnt - d0, 1);
      chk("s5b_cnt", b_out_cnt, 2);
      // reset during the second epoch of a longer job
      w0 = wq.size();
      go(64, 3);
      fork
         send(12, 4);
         begin
            t = 0;
            while (wq.size() - w0 < 10 && t < 400) begin
               @(negedge hbm_clk);
               t++;
            end
            chk("s6_reach_epoch2", t < 400, 1);
            #2 rst = 1'b1;
            #1;
            chk("s6_rst_ready", bif.hbm_b_ready, 0);
            chk("s6_rst_wr_en", bif.dispatch_axb_b_wr_en, 0);
            chk("s6_rst_data", bif.dispatch_axb_b_data, 0);
            chk("s6_rst_busy", busy, 0);
            chk("s6_rst_cnt", b_out_cnt, 0);
            abort = 1'b1;
         end
      join
      repeat (2) @(negedge hbm_clk);
      rst = 1'b0; abort = 1'b0;
      w0 = wq.size(); d0 = done_cnt;
      repeat (4) @(negedge hbm_clk);
      chk("s6_quiet_words", wq.size() - w0, 0);
      chk("s6_quiet_done", done_cnt - d0, 0);
      job16("s6");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
